// File: rtl/l1_l2_port_arb_pkg.sv
// Shared types and default widths for the L1 -> L2 port arbiter.
// State encoding is fixed so that debug tooling can decode it from the raw bits.
package l1_l2_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINE_W = 128;

    // Width of a channel id; a single-channel build still carries a 1-bit id.
    function automatic int ch_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l1_l2_port_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting index at or after ptr, wrapping.
// The pointer register lives in the parent.
module l1_l2_port_arb_rr_arbiter
    import l1_l2_port_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int CH_W = ch_id_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any_req
);

    logic found;

    // First pass covers [ptr, NUM_CH-1], second pass the wrapped range [0, ptr-1].
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        any_req = |req;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found = 1'b1;
                grant = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                grant = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/l1_l2_port_arb.sv
// N-channel round-robin arbiter merging L1 miss/write ports onto one L2 port,
// one outstanding transaction. Optional write snoop invalidates: `L1_SNOOP_INV_EN.
module l1_l2_port_arb
    import l1_l2_port_arb_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINE_W = DEF_LINE_W,
    localparam int CH_W = ch_id_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_rd_wr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_din,
    output logic [NUM_CH-1:0]        ch_page_wr,
    output logic [LINE_W-1:0]        ch_page_dout,
    output logic [NUM_CH-1:0]        ch_wr_ack,
    output logic [NUM_CH-1:0]        ch_dirty,
    output logic [ADDR_W-1:0]        ch_dirty_addr,
    output logic                     l2_valid,
    output logic                     l2_rd_wr,
    output logic [ADDR_W-1:0]        l2_addr,
    output logic [DATA_W-1:0]        l2_din,
    output logic [CH_W-1:0]          l2_ch,
    input  logic                     l2_page_wr,
    input  logic [LINE_W-1:0]        l2_page_dout,
    input  logic                     l2_wr_ack,
    input  logic                     l2_dirty,
    input  logic [ADDR_W-1:0]        l2_dirty_addr,
    output logic                     resp_err
);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d, g_q, g_d, gnt;
    logic [NUM_CH-1:0] mask_q, mask_d, onehot_g, page_wr_q, page_wr_d, wr_ack_q, wr_ack_d;
    logic [NUM_CH-1:0] dirty_q, dirty_d;
    logic [ADDR_W-1:0] addr_q, addr_d, dirty_addr_q, dirty_addr_d, sel_addr;
    logic [DATA_W-1:0] din_q, din_d, sel_din;
    logic [LINE_W-1:0] line_q, line_d;
    logic              rd_wr_q, rd_wr_d, l2_valid_q, l2_valid_d, err_q, err_d, sel_rd_wr, any_req;

    l1_l2_port_arb_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req     (ch_valid & ~mask_q),
        .ptr     (ptr_q),
        .grant   (gnt),
        .any_req (any_req)
    );

    assign onehot_g = NUM_CH'(1) << g_q;

    always_comb begin
        sel_rd_wr = 1'b0;
        sel_addr  = '0;
        sel_din   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == gnt) begin
                sel_rd_wr = ch_rd_wr[k];
                sel_addr  = ch_addr[k*ADDR_W +: ADDR_W];
                sel_din   = ch_din[k*DATA_W +: DATA_W];
            end
        end
    end

    // resp_err is registered: it pulses in the cycle after the offending response.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mask_d     = mask_q;
        g_d        = g_q;
        rd_wr_d    = rd_wr_q;
        addr_d     = addr_q;
        din_d      = din_q;
        l2_valid_d = l2_valid_q;
        line_d     = line_q;
        page_wr_d  = '0;
        wr_ack_d   = '0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mask_d = '0;
                err_d  = l2_page_wr | l2_wr_ack;
                if (any_req) begin
                    state_d    = ST_BUSY;
                    g_d        = gnt;
                    rd_wr_d    = sel_rd_wr;
                    addr_d     = sel_addr;
                    din_d      = sel_din;
                    l2_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (rd_wr_q) begin
                    err_d = l2_page_wr;
                    if (l2_wr_ack) begin
                        state_d    = ST_RESP;
                        l2_valid_d = 1'b0;
                        wr_ack_d   = onehot_g;
                    end
                end else begin
                    err_d = l2_wr_ack;
                    if (l2_page_wr) begin
                        state_d    = ST_RESP;
                        l2_valid_d = 1'b0;
                        line_d     = l2_page_dout;
                        page_wr_d  = onehot_g;
                    end
                end
            end
            ST_RESP: begin
                err_d   = l2_page_wr | l2_wr_ack;
                ptr_d   = (int'(g_q) == NUM_CH - 1) ? '0 : g_q + CH_W'(1);
                mask_d  = onehot_g;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef L1_SNOOP_INV_EN
    logic              snoop_wr, pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    assign snoop_wr = (state_q == ST_BUSY) && rd_wr_q && l2_wr_ack;

    // A write snoop owns the dirty strobe; a colliding L2 invalidate waits one cycle.
    always_comb begin
        dirty_d      = '0;
        dirty_addr_d = dirty_addr_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        if (snoop_wr) begin
            dirty_d      = ~onehot_g;
            dirty_addr_d = addr_q;
            if (l2_dirty) begin
                pend_d      = 1'b1;
                pend_addr_d = l2_dirty_addr;
            end
        end else if (l2_dirty) begin
            dirty_d      = '1;
            dirty_addr_d = l2_dirty_addr;
            pend_d       = 1'b0;
        end else if (pend_q) begin
            dirty_d      = '1;
            dirty_addr_d = pend_addr_q;
            pend_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end
`else
    always_comb begin
        dirty_d      = {NUM_CH{l2_dirty}};
        dirty_addr_d = l2_dirty_addr;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            mask_q       <= '0;
            g_q          <= '0;
            rd_wr_q      <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            l2_valid_q   <= 1'b0;
            line_q       <= '0;
            page_wr_q    <= '0;
            wr_ack_q     <= '0;
            err_q        <= 1'b0;
            dirty_q      <= '0;
            dirty_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            mask_q       <= mask_d;
            g_q          <= g_d;
            rd_wr_q      <= rd_wr_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            l2_valid_q   <= l2_valid_d;
            line_q       <= line_d;
            page_wr_q    <= page_wr_d;
            wr_ack_q     <= wr_ack_d;
            err_q        <= err_d;
            dirty_q      <= dirty_d;
            dirty_addr_q <= dirty_addr_d;
        end
    end

    assign l2_valid      = l2_valid_q;
    assign l2_rd_wr      = rd_wr_q;
    assign l2_addr       = addr_q;
    assign l2_din        = din_q;
    assign l2_ch         = g_q;
    assign ch_page_wr    = page_wr_q;
    assign ch_page_dout  = line_q;
    assign ch_wr_ack     = wr_ack_q;
    assign ch_dirty      = dirty_q;
    assign ch_dirty_addr = dirty_addr_q;
    assign resp_err      = err_q;

endmodule

// File: tb/tb_l1_l2_port_arb.sv
// Directed bench for l1_l2_port_arb (4 channels) with a transaction-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_l1_l2_port_arb;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int LINE_W = 128;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUM_CH-1:0]        ch_valid, ch_rd_wr;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_din;
    logic [NUM_CH-1:0]        ch_page_wr, ch_wr_ack, ch_dirty;
    logic [LINE_W-1:0]        ch_page_dout;
    logic [ADDR_W-1:0]        ch_dirty_addr, l2_addr, l2_dirty_addr;
    logic                     l2_valid, l2_rd_wr, l2_page_wr, l2_wr_ack, l2_dirty, resp_err;
    logic [DATA_W-1:0]        l2_din;
    logic [CH_W-1:0]          l2_ch;
    logic [LINE_W-1:0]        l2_page_dout;

    l1_l2_port_arb #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .ch_valid(ch_valid), .ch_rd_wr(ch_rd_wr), .ch_addr(ch_addr), .ch_din(ch_din),
        .ch_page_wr(ch_page_wr), .ch_page_dout(ch_page_dout), .ch_wr_ack(ch_wr_ack),
        .ch_dirty(ch_dirty), .ch_dirty_addr(ch_dirty_addr),
        .l2_valid(l2_valid), .l2_rd_wr(l2_rd_wr), .l2_addr(l2_addr), .l2_din(l2_din), .l2_ch(l2_ch),
        .l2_page_wr(l2_page_wr), .l2_page_dout(l2_page_dout), .l2_wr_ack(l2_wr_ack),
        .l2_dirty(l2_dirty), .l2_dirty_addr(l2_dirty_addr), .resp_err(resp_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase of the single outstanding transaction: 0 none, 1 waiting on L2, 2 answering channel.
    int                m_phase, m_ptr, m_ch;
    bit                m_found, m_snoop, m_pend, m_wr;
    int                m_idx;
    logic [NUM_CH-1:0] m_block, m_elig;
    logic [ADDR_W-1:0] m_addr, m_pend_addr;
    logic [DATA_W-1:0] m_din;
    logic              e_valid, e_err;
    logic [NUM_CH-1:0] e_page_wr, e_wr_ack, e_dirty;
    logic [LINE_W-1:0] e_line;
    logic [ADDR_W-1:0] e_daddr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_ptr = 0; m_ch = 0; m_block = '0; m_wr = 0;
            m_addr = '0; m_din = '0; m_pend = 0; m_pend_addr = '0;
            e_valid = 0; e_err = 0; e_page_wr = '0; e_wr_ack = '0;
            e_dirty = '0; e_line = '0; e_daddr = '0;
        end else begin
            m_snoop   = 0;
            e_page_wr = '0;
            e_wr_ack  = '0;
            e_err     = 0;
            if (m_phase == 0) begin
                m_elig  = ch_valid & ~m_block;
                m_block = '0;
                e_err   = l2_page_wr || l2_wr_ack;
                m_found = 0;
                for (int k = 0; k < NUM_CH; k++) begin
                    m_idx = (m_ptr + k) % NUM_CH;
                    if (!m_found && m_elig[m_idx]) begin
                        m_found = 1;
                        m_ch    = m_idx;
                    end
                end
                if (m_found) begin
                    m_wr    = ch_rd_wr[m_ch];
                    m_addr  = ch_addr[m_ch*ADDR_W +: ADDR_W];
                    m_din   = ch_din[m_ch*DATA_W +: DATA_W];
                    e_valid = 1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_wr) begin
                    e_err = l2_page_wr;
                    if (l2_wr_ack) begin
                        e_wr_ack[m_ch] = 1'b1;
                        e_valid = 0; m_phase = 2; m_snoop = 1;
                    end
                end else begin
                    e_err = l2_wr_ack;
                    if (l2_page_wr) begin
                        e_page_wr[m_ch] = 1'b1;
                        e_line  = l2_page_dout;
                        e_valid = 0; m_phase = 2;
                    end
                end
            end else begin
                e_err   = l2_page_wr || l2_wr_ack;
                m_ptr   = (m_ch + 1) % NUM_CH;
                m_block = '0;
                m_block[m_ch] = 1'b1;
                m_phase = 0;
            end
`ifdef L1_SNOOP_INV_EN
            if (m_snoop) begin
                e_dirty = '1;
                e_dirty[m_ch] = 1'b0;
                e_daddr = m_addr;
                if (l2_dirty) begin m_pend = 1; m_pend_addr = l2_dirty_addr; end
            end else if (l2_dirty) begin
                e_dirty = '1; e_daddr = l2_dirty_addr; m_pend = 0;
            end else if (m_pend) begin
                e_dirty = '1; e_daddr = m_pend_addr; m_pend = 0;
            end else begin
                e_dirty = '0;
            end
`else
            e_dirty = l2_dirty ? '1 : '0;
            e_daddr = l2_dirty_addr;
`endif
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("m_l2_valid", l2_valid, e_valid);
            if (e_valid) begin
                check("m_l2_rd_wr", l2_rd_wr, m_wr);
                check("m_l2_addr", l2_addr, m_addr);
                check("m_l2_din", l2_din, m_din);
                check("m_l2_ch", l2_ch, m_ch);
            end
            check("m_page_wr", ch_page_wr, e_page_wr);
            if (e_page_wr != 0) check("m_page_dout", ch_page_dout, e_line);
            check("m_wr_ack", ch_wr_ack, e_wr_ack);
            check("m_dirty", ch_dirty, e_dirty);
            if (e_dirty != 0) check("m_dirty_addr", ch_dirty_addr, e_daddr);
            check("m_resp_err", resp_err, e_err);
        end
    end

    // ---------------- response log / scoreboard ----------------
    int mon_idx;
    int resp_ch[$];
    int resp_cyc[$];
    logic [CH_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst && ch_page_wr != 0) begin
            mon_idx = 0;
            for (int k = 0; k < NUM_CH; k++) if (ch_page_wr[k]) mon_idx = k;
            resp_ch.push_back(mon_idx);
            resp_cyc.push_back(cycle);
        end
    end

    // Auto responder: answers a read in the same cycle l2_valid is seen.
    bit auto_resp = 0;
    always @(posedge clk) begin
        #1;
        if (auto_resp) begin
            l2_page_dout = {4{32'(cycle)}};
            l2_page_wr   = l2_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input bit v, input bit wr,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ch_valid[k] = v;
        ch_rd_wr[k] = wr;
        ch_addr[k*ADDR_W +: ADDR_W] = a;
        ch_din[k*DATA_W +: DATA_W]  = d;
    endtask

    task automatic wait_l2_valid(input string name);
        int n;
        n = 0;
        while (!l2_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_l2_valid"}, l2_valid, 1);
    endtask

    task automatic check_zero(input string name);
        check({name, "_l2_valid"}, l2_valid, 0);
        check({name, "_l2_rd_wr"}, l2_rd_wr, 0);
        check({name, "_l2_addr"}, l2_addr, 0);
        check({name, "_l2_din"}, l2_din, 0);
        check({name, "_l2_ch"}, l2_ch, 0);
        check({name, "_page_wr"}, ch_page_wr, 0);
        check({name, "_page_dout"}, ch_page_dout, 0);
        check({name, "_wr_ack"}, ch_wr_ack, 0);
        check({name, "_dirty"}, ch_dirty, 0);
        check({name, "_dirty_addr"}, ch_dirty_addr, 0);
        check({name, "_resp_err"}, resp_err, 0);
    endtask

    task automatic serve_read(input string name, input int exp_ch, input logic [LINE_W-1:0] line);
        wait_l2_valid(name);
        check({name, "_ch"}, l2_ch, exp_ch);
        l2_page_dout = line;
        l2_page_wr   = 1'b1;
        tick();
        l2_page_wr   = 1'b0;
        check({name, "_resp"}, ch_page_wr, NUM_CH'(1) << exp_ch);
        set_ch(exp_ch, 0, 0, '0, '0);
    endtask

    // ---------------- directed stimulus ----------------
    localparam logic [LINE_W-1:0] LINE_A5 = 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    int n;

    initial begin
        ch_valid = '0; ch_rd_wr = '0; ch_addr = '0; ch_din = '0;
        l2_page_wr = 0; l2_page_dout = '0; l2_wr_ack = 0; l2_dirty = 0; l2_dirty_addr = '0;
        rst = 0;
        tick(2);
        check_zero("reset");
        rst = 1;
        tick();

        // Single read on ch0, L2 answers two cycles after l2_valid.
        set_ch(0, 1, 0, 14'h0123, '0);
        wait_l2_valid("t1");
        check("t1_addr", l2_addr, 14'h0123);
        check("t1_ch", l2_ch, 0);
        check("t1_rd_wr", l2_rd_wr, 0);
        tick(2);
        l2_page_dout = LINE_A5;
        l2_page_wr   = 1;
        tick();
        l2_page_wr   = 0;
        check("t1_page_wr", ch_page_wr, 4'b0001);
        check("t1_line", ch_page_dout, LINE_A5);
        check("t1_wr_ack", ch_wr_ack, 4'b0000);
        set_ch(0, 0, 0, '0, '0);
        tick(2);

        // Round robin from a fresh pointer: all four request together.
        rst = 0; #2; rst = 1;
        tick();
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 1, 0, 14'(16'h0100 + k), '0);
        serve_read("t2_g0", 0, {4{32'h1000_0000}});
        serve_read("t2_g1", 1, {4{32'h1000_0001}});
        serve_read("t2_g2", 2, {4{32'h1000_0002}});
        wait_l2_valid("t2_g3");
        check("t2_g3_ch", l2_ch, 3);
        l2_page_dout = {4{32'h1000_0003}};
        l2_page_wr   = 1;
        tick();
        l2_page_wr   = 0;
        check("t2_g3_resp", ch_page_wr, 4'b1000);
        // ch3 stays up through the first idle cycle and must not be re-granted.
        tick(2);
        check("t2_mask", l2_valid, 0);
        set_ch(3, 0, 0, '0, '0);
        set_ch(0, 1, 0, 14'h0180, '0);
        set_ch(2, 1, 0, 14'h0182, '0);
        serve_read("t2_wrap0", 0, {4{32'h2000_0000}});
        serve_read("t2_then2", 2, {4{32'h2000_0002}});
        tick();

        // Write on ch1 with a coincident L2 invalidate.
        set_ch(1, 1, 1, 14'h0040, 32'hDEADBEEF);
        wait_l2_valid("t3");
        check("t3_ch", l2_ch, 1);
        check("t3_rd_wr", l2_rd_wr, 1);
        check("t3_din", l2_din, 32'hDEADBEEF);
        l2_wr_ack = 1; l2_dirty = 1; l2_dirty_addr = 14'h2AAA;
        tick();
        l2_wr_ack = 0; l2_dirty = 0;
        check("t3_wr_ack", ch_wr_ack, 4'b0010);
        check("t3_page_wr", ch_page_wr, 4'b0000);
        set_ch(1, 0, 0, '0, '0);
`ifdef L1_SNOOP_INV_EN
        check("t3_snoop", ch_dirty, 4'b1101);
        check("t3_snoop_addr", ch_dirty_addr, 14'h0040);
        tick();
        check("t3_late_inv", ch_dirty, 4'b1111);
        check("t3_late_inv_addr", ch_dirty_addr, 14'h2AAA);
`else
        check("t3_inv", ch_dirty, 4'b1111);
        check("t3_inv_addr", ch_dirty_addr, 14'h2AAA);
        tick();
        check("t3_inv_gone", ch_dirty, 4'b0000);
`endif
        tick();
        l2_dirty = 1; l2_dirty_addr = 14'h0155;
        tick();
        l2_dirty = 0;
        check("t3_idle_inv", ch_dirty, 4'b1111);
        check("t3_idle_inv_addr", ch_dirty_addr, 14'h0155);
        tick();

        // Wrong-type response during a read, then a response while idle.
        set_ch(2, 1, 0, 14'h0200, '0);
        wait_l2_valid("t4");
        l2_wr_ack = 1;
        tick();
        l2_wr_ack = 0;
        check("t4_err", resp_err, 1);
        check("t4_still_busy", l2_valid, 1);
        tick();
        check("t4_err_clear", resp_err, 0);
        serve_read("t4_done", 2, LINE_A5);
        tick(2);
        l2_page_wr = 1;
        tick();
        l2_page_wr = 0;
        check("t4_idle_err", resp_err, 1);
        check("t4_idle_no_fill", ch_page_wr, 4'b0000);
        tick();

        // Reset while busy; pointer must restart at 0 (otherwise ch3 would win).
        set_ch(1, 1, 0, 14'h0300, '0);
        wait_l2_valid("t5");
        check("t5_first_ch", l2_ch, 1);
        set_ch(3, 1, 0, 14'h0333, '0);
        #2;
        rst = 0;
        #1;
        check_zero("t5_async");
        @(posedge clk);
        #1;
        rst = 1;
        serve_read("t5_fresh", 1, {4{32'h3000_0001}});
        serve_read("t5_next", 3, {4{32'h3000_0003}});
        tick();

        // Back-to-back throughput with an immediately answering L2.
        resp_ch.delete();
        resp_cyc.delete();
        set_ch(0, 1, 0, 14'h0010, '0);
        set_ch(2, 1, 0, 14'h0020, '0);
        auto_resp = 1;
        n = 0;
        while (n < 60 && !(resp_ch.size() >= 6 && ch_page_wr != 0)) begin
            tick();
            n++;
        end
        check("t6_bound", n < 60, 1);
        set_ch(0, 0, 0, '0, '0);
        set_ch(2, 0, 0, '0, '0);
        tick();
        auto_resp  = 0;
        l2_page_wr = 0;
        tick(2);
        check("t6_count", resp_ch.size() >= 6, 1);
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 2'd0 : 2'd2);
        for (int i = 0; i < 6 && i < resp_ch.size(); i++) begin
            check("t6_order", resp_ch[i], exp_q.pop_front());
            if (i > 0) check("t6_gap", resp_cyc[i] - resp_cyc[i-1], 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog act=running exp=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l1_l2_port_arb.md
Name: l1_l2_port_arb

Overview:
- Parametrised N-channel arbiter that merges the L1 cache miss/write ports (inst and data of one or more cores) onto a single L2 request port.
- Sits between the cache_l1 instances and the L2 in each core wrapper, replacing the fixed one-inst/one-data point-to-point wiring.
- Round-robin grant with one outstanding L2 transaction.
- Routes page fills and write acks back to the requesting channel.
- Generates dirty/invalidate notifications to the L1 channels.

Parameters:
- NUM_CH, 2, number of L1 channels (2..8).
- ADDR_W, 14, word address width.
- DATA_W, 32, write data width.
- LINE_W, 128, page/line fill width.
- CH_W, $clog2(NUM_CH) (min 1), grant id width (derived, localparam).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- ch_valid  in  NUM_CH  per-channel request, held until that channel's response.
- ch_rd_wr  in  NUM_CH  per-channel 0 = read/fill, 1 = write.
- ch_addr  in  NUM_CH*ADDR_W  flattened request addresses, channel k at [k*ADDR_W +: ADDR_W].
- ch_din  in  NUM_CH*DATA_W  flattened write data.
- ch_page_wr  out  NUM_CH  one-cycle fill strobe to the granted channel.
- ch_page_dout  out  LINE_W  fill line, shared by all channels; valid while ch_page_wr[k] is high.
- ch_wr_ack  out  NUM_CH  one-cycle write acknowledge.
- ch_dirty  out  NUM_CH  one-cycle invalidate strobe.
- ch_dirty_addr  out  ADDR_W  invalidate address, shared.
- l2_valid  out  1  L2 request.
- l2_rd_wr  out  1  L2 read/write.
- l2_addr  out  ADDR_W  L2 address.
- l2_din  out  DATA_W  L2 write data.
- l2_ch  out  CH_W  id of the channel being served.
- l2_page_wr  in  1  L2 fill strobe.
- l2_page_dout  in  LINE_W  L2 fill line.
- l2_wr_ack  in  1  L2 write acknowledge.
- l2_dirty  in  1  L2-originated invalidate.
- l2_dirty_addr  in  ADDR_W  address of the L2-originated invalidate.
- resp_err  out  1  one-cycle pulse on an unexpected L2 response.

Behaviour:
- Reset (rst=0, async):
  - All outputs 0; state IDLE; rr pointer 0; mask cleared.
  - Any in-flight L2 transaction is abandoned; the L2 is reset from the same rst.
- State machine: IDLE, BUSY, RESP.
- IDLE:
  - Eligible = ch_valid & ~mask.
  - If any channel is eligible, grant the first eligible index at or after the pointer, searching upward with wrap NUM_CH-1 -> 0.
  - Latch g, rd_wr, addr and din; go to BUSY.
  - The mask clears at the end of every IDLE cycle.
- BUSY:
  - l2_valid=1 with latched fields; l2_ch=g. First l2_valid is 1 cycle after grant.
  - Read: wait for l2_page_wr, capture l2_page_dout, go to RESP.
  - Write: wait for l2_wr_ack, go to RESP.
  - Wrong-type response (ack during a read, page_wr during a write): ignored, resp_err=1 for that cycle, stay in BUSY.
  - l2_valid drops in the cycle after the accepted response.
  - No timeout; BUSY waits indefinitely.
- RESP (exactly 1 cycle):
  - ch_page_wr[g]=1 with ch_page_dout=captured line, or ch_wr_ack[g]=1.
  - pointer <= g+1 mod NUM_CH; mask <= one-hot g; go to IDLE.
  - The mask gives channel g a one-cycle blackout so a late-dropping valid is not re-issued.
- Channels must keep valid/rd_wr/addr/din stable until their response, and drop valid within 1 cycle after it.
- Latency (L2 responding in the same cycle it sees l2_valid):
  - grant cycle N; l2_valid at N+1; channel response at N+2; next grant earliest N+3.
- Any response arriving in IDLE or RESP: ignored, resp_err pulse.
- New requests arriving during BUSY/RESP wait; no queue beyond the channel's held valid.
- NUM_CH=1: the pointer stays 0 and the mask still applies.

Optional Feature:
- Macro L1_SNOOP_INV_EN.
- Defined:
  - In the RESP cycle of a write, ch_dirty[k]=1 for every k != g, with ch_dirty_addr = latched addr.
  - An l2_dirty in the same cycle is delayed 1 cycle (held in a single register). It is then broadcast to all channels with l2_dirty_addr.
  - If a second l2_dirty arrives while one is pending, the newer one overwrites it.
- Undefined:
  - ch_dirty = {NUM_CH{l2_dirty}} and ch_dirty_addr = l2_dirty_addr, both registered with 1-cycle latency.
  - Writes generate no snoop.

Decomposition:
- Shared package: state encoding (IDLE=0, BUSY=1, RESP=2), default widths ADDR_W=14, DATA_W=32, LINE_W=128.
- One sub-module, rr_arbiter: inputs req[NUM_CH] and pointer; outputs the grant index and any_req. Purely combinational; the pointer register stays in the parent.

Test Plan:
- Single read, NUM_CH=2:
  - Stimulus: ch0 read addr 0x0123; L2 answers page_wr with 128'hA5... 2 cycles after l2_valid.
  - Required: l2_addr=0x0123, l2_ch=0; ch_page_wr=2'b01 for 1 cycle with the line; ch_wr_ack stays 0.
- Round-robin, NUM_CH=4:
  - Stimulus: all four channels request together, pointer=0.
  - Required: grants in order 0,1,2,3.
  - Then ch0 re-requests while ch2 is requesting: grant goes to ch0 after the 3->0 wrap; a late-held ch3 is masked for 1 cycle.
- Write with snoop (L1_SNOOP_INV_EN):
  - Stimulus: ch1 writes addr 0x0040, data 0xDEADBEEF.
  - Required: l2_din=0xDEADBEEF; ch_wr_ack=2'b10; ch_dirty=2'b01, ch_dirty_addr=0x0040 in the same cycle.
- Unexpected response:
  - l2_wr_ack during a read BUSY -> resp_err=1 for 1 cycle, still BUSY.
  - The later page_wr completes normally.
- Reset mid-BUSY:
  - Stimulus: rst low while l2_valid=1.
  - Required: all outputs 0 immediately (async); after release, a held ch_valid is granted fresh from pointer 0.
- Back-to-back throughput:
  - Stimulus: two channels requesting continuously, L2 responding in the same cycle as l2_valid.
  - Required: one response every 3 cycles, alternating channels.
